// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//
// Handshake: a requester raises x_req with x_we/x_addr/x_wdata stable and
// keeps them stable until x_gnt is seen high in the same cycle; the request is
// consumed by that grant, so the inputs may change in the next cycle. Read
// responses need no acknowledgement: x_rvalid is a one-cycle pulse with x_rdata
// and x_err, and responses come back in grant order.
interface data_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          a_err;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;
  logic          b_err;

  logic          mem_cs;
  logic          mem_we;
  logic [8:0]    mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata, a_err,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata, b_err,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters plus memory side
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata, a_err,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata, b_err,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter for the 16-bit x 512-word data memory.
// A (CPU load/store) has fixed priority; B (debug/loader) is forced through
// after MAX_WAIT denied cycles. One registered memory command per cycle, an
// owner-tag shift register routes read data back to the right requester.
module data_mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int DEPTH    = 512,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic                Clock,
  input  logic                reset,
  data_mem_arbiter_if.slave   io_bus,
  output logic                o_dbg_state,
  output logic [3:0]          o_dbg_wait_cnt
);

  typedef enum logic {
    PRIO_A  = 1'b0,
    FORCE_B = 1'b1
  } state_t;

  localparam logic [AW-1:0] DEPTH_L = AW'(DEPTH);
  localparam logic [3:0]    WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_wait_cnt, w_wait_nxt;
  logic          w_a_gnt, w_b_gnt, w_any_gnt;

  logic          w_a_oor, w_b_oor, w_sel_oor, w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  logic          r_mem_cs, r_mem_we;
  logic [8:0]    r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  // Tag pipeline, bit 0 is the newest slot, bit RD_LAT lines up with mem_rdata
  logic [RD_LAT:0] r_tag_rd, r_tag_b, r_tag_oor;
  logic            r_werr_a, r_werr_b;

  logic          w_rsp_rd, w_rsp_b, w_rsp_oor;
  logic [DW-1:0] w_rsp_data;
  logic          w_a_rvalid, w_b_rvalid;
  logic [DW-1:0] r_a_rdata, r_b_rdata;

  assign w_a_oor = (io_bus.a_addr >= DEPTH_L);
  assign w_b_oor = (io_bus.b_addr >= DEPTH_L);

  // Grant decision, next state and B starvation counter
  always_comb begin
    w_a_gnt     = 1'b0;
    w_b_gnt     = 1'b0;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    // No grant while reset is low so a requester never loses a request
    // whose command would be suppressed.
    if (reset) begin
      case (r_state)
        PRIO_A: begin
          if (io_bus.a_req)      w_a_gnt = 1'b1;
          else if (io_bus.b_req) w_b_gnt = 1'b1;
          if (io_bus.b_req && !w_b_gnt && (r_wait_cnt == WAIT_LAST))
            w_state_nxt = FORCE_B;
        end
        FORCE_B: begin
          // A is held off for this slot; leave whether or not B still wants it
          w_b_gnt     = io_bus.b_req;
          w_state_nxt = PRIO_A;
        end
        default: w_state_nxt = PRIO_A;
      endcase
      if (w_b_gnt || (r_state == FORCE_B))
        w_wait_nxt = 4'd0;
      else if (io_bus.b_req && (r_wait_cnt != 4'hF))
        w_wait_nxt = r_wait_cnt + 4'd1;
    end
  end

  assign w_any_gnt   = w_a_gnt | w_b_gnt;
  assign w_sel_we    = w_b_gnt ? io_bus.b_we    : io_bus.a_we;
  assign w_sel_addr  = w_b_gnt ? io_bus.b_addr  : io_bus.a_addr;
  assign w_sel_wdata = w_b_gnt ? io_bus.b_wdata : io_bus.a_wdata;
  assign w_sel_oor   = w_b_gnt ? w_b_oor        : w_a_oor;

  // FSM state and wait counter registers
  always_ff @(posedge Clock) begin
    if (!reset) begin
      r_state    <= PRIO_A;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Register the granted command; out-of-range slots never enable the memory
  always_ff @(posedge Clock) begin
    if (!reset) begin
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_cs <= w_any_gnt && !w_sel_oor;
      r_mem_we <= w_any_gnt && w_sel_we && !w_sel_oor;
      if (w_any_gnt) begin
        r_mem_addr  <= w_sel_addr[8:0];
        r_mem_wdata <= w_sel_wdata;
      end
    end
  end

  // Owner tags for reads in flight, plus write-error pulses for T+1
  always_ff @(posedge Clock) begin
    if (!reset) begin
      r_tag_rd  <= '0;
      r_tag_b   <= '0;
      r_tag_oor <= '0;
      r_werr_a  <= 1'b0;
      r_werr_b  <= 1'b0;
    end else begin
      r_tag_rd  <= {r_tag_rd[RD_LAT-1:0],  w_any_gnt && !w_sel_we};
      r_tag_b   <= {r_tag_b[RD_LAT-1:0],   w_b_gnt};
      r_tag_oor <= {r_tag_oor[RD_LAT-1:0], w_sel_oor};
      r_werr_a  <= w_a_gnt && io_bus.a_we && w_a_oor;
      r_werr_b  <= w_b_gnt && io_bus.b_we && w_b_oor;
    end
  end

  assign w_rsp_rd   = r_tag_rd[RD_LAT];
  assign w_rsp_b    = r_tag_b[RD_LAT];
  assign w_rsp_oor  = r_tag_oor[RD_LAT];
  assign w_rsp_data = w_rsp_oor ? '0 : io_bus.mem_rdata;
  assign w_a_rvalid = w_rsp_rd && !w_rsp_b;
  assign w_b_rvalid = w_rsp_rd &&  w_rsp_b;

  // Remember the last delivered read data so rdata holds between pulses
  always_ff @(posedge Clock) begin
    if (!reset) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (w_a_rvalid) r_a_rdata <= w_rsp_data;
      if (w_b_rvalid) r_b_rdata <= w_rsp_data;
    end
  end

  assign io_bus.a_gnt     = w_a_gnt;
  assign io_bus.b_gnt     = w_b_gnt;
  assign io_bus.a_rvalid  = w_a_rvalid;
  assign io_bus.b_rvalid  = w_b_rvalid;
  assign io_bus.a_rdata   = w_a_rvalid ? w_rsp_data : r_a_rdata;
  assign io_bus.b_rdata   = w_b_rvalid ? w_rsp_data : r_b_rdata;
  assign io_bus.a_err     = (w_a_rvalid && w_rsp_oor) || r_werr_a;
  assign io_bus.b_err     = (w_b_rvalid && w_rsp_oor) || r_werr_b;
  assign io_bus.mem_cs    = r_mem_cs;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;

  assign o_dbg_state    = r_state;
  assign o_dbg_wait_cnt = r_wait_cnt;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: cycle table of requests and expected outputs,
// plus hand-written sequences for B starvation and reset mid-read.
module tb_data_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       dbg_state;
  logic [3:0] dbg_wait;
  int         checks;
  int         failures;

  data_mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  data_mem_arbiter #(
    .AW(16), .DW(16), .DEPTH(512), .RD_LAT(1), .MAX_WAIT(4)
  ) dut (
    .Clock          (clk),
    .reset          (rst_n),
    .io_bus         (bus),
    .o_dbg_state    (dbg_state),
    .o_dbg_wait_cnt (dbg_wait)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model, one-cycle read latency
  logic [15:0] mem_arr [0:511];
  always @(posedge clk) begin
    if (!rst_n) bus.mem_rdata <= 16'h0;
    else if (bus.mem_cs) begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_arr[bus.mem_addr];
    end
  end

  typedef struct {
    logic        a_req, a_we;
    logic [15:0] a_addr, a_wdata;
    logic        b_req, b_we;
    logic [15:0] b_addr, b_wdata;
    logic        e_a_gnt, e_b_gnt, e_cs, e_we;
    logic [8:0]  e_addr;
    logic [15:0] e_wdata;
    logic        e_a_rv;
    logic [15:0] e_a_rd;
    logic        e_a_err;
    logic        e_b_rv;
    logic [15:0] e_b_rd;
    logic        e_b_err;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input vec_t v);
    bus.a_req = v.a_req; bus.a_we = v.a_we; bus.a_addr = v.a_addr; bus.a_wdata = v.a_wdata;
    bus.b_req = v.b_req; bus.b_we = v.b_we; bus.b_addr = v.b_addr; bus.b_wdata = v.b_wdata;
  endtask

  task automatic idle_inputs();
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
  endtask

  task automatic apply_vec(input int i, input vec_t v);
    @(posedge clk); #1;
    set_inputs(v);
    @(negedge clk);
    check($sformatf("v%0d a_gnt", i),    bus.a_gnt,    v.e_a_gnt);
    check($sformatf("v%0d b_gnt", i),    bus.b_gnt,    v.e_b_gnt);
    check($sformatf("v%0d mem_cs", i),   bus.mem_cs,   v.e_cs);
    check($sformatf("v%0d mem_we", i),   bus.mem_we,   v.e_we);
    if (v.e_cs) check($sformatf("v%0d mem_addr", i), bus.mem_addr, v.e_addr);
    if (v.e_cs && v.e_we) check($sformatf("v%0d mem_wdata", i), bus.mem_wdata, v.e_wdata);
    check($sformatf("v%0d a_rvalid", i), bus.a_rvalid, v.e_a_rv);
    check($sformatf("v%0d a_rdata", i),  bus.a_rdata,  v.e_a_rd);
    check($sformatf("v%0d a_err", i),    bus.a_err,    v.e_a_err);
    check($sformatf("v%0d b_rvalid", i), bus.b_rvalid, v.e_b_rv);
    check($sformatf("v%0d b_rdata", i),  bus.b_rdata,  v.e_b_rd);
    check($sformatf("v%0d b_err", i),    bus.b_err,    v.e_b_err);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int k = 0; k < 512; k++) mem_arr[k] = 16'h0;
    mem_arr[0] = 16'h0A0A;
    mem_arr[1] = 16'h1111;
    mem_arr[2] = 16'h2222;
    mem_arr[3] = 16'h3333;
    mem_arr[4] = 16'h4444;
    mem_arr[5] = 16'h1234;

    //            a: req we addr     wdata     b: req we addr     wdata     gA gB cs we addr    wdata     aRv aRd      aE  bRv bRd      bE
    vecs.push_back(vec_t'{1,0,16'h0005,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0,0,9'h000,16'h0000, 0,16'h0000,0, 0,16'h0000,0}); // A rd 5
    vecs.push_back(vec_t'{1,1,16'h01FF,16'hBEEF, 0,0,16'h0000,16'h0000, 1,0,1,0,9'h005,16'h0000, 0,16'h0000,0, 0,16'h0000,0}); // A wr 1FF
    vecs.push_back(vec_t'{1,0,16'h01FF,16'h0000, 0,0,16'h0000,16'h0000, 1,0,1,1,9'h1FF,16'hBEEF, 1,16'h1234,0, 0,16'h0000,0}); // A rd 1FF
    vecs.push_back(vec_t'{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,1,0,9'h1FF,16'h0000, 0,16'h1234,0, 0,16'h0000,0});
    vecs.push_back(vec_t'{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,9'h000,16'h0000, 1,16'hBEEF,0, 0,16'h0000,0});
    vecs.push_back(vec_t'{1,0,16'h0001,16'h0000, 1,0,16'h0002,16'h0000, 1,0,0,0,9'h000,16'h0000, 0,16'hBEEF,0, 0,16'h0000,0}); // both: A wins
    vecs.push_back(vec_t'{0,0,16'h0000,16'h0000, 1,0,16'h0002,16'h0000, 0,1,1,0,9'h001,16'h0000, 0,16'hBEEF,0, 0,16'h0000,0}); // B held
    vecs.push_back(vec_t'{1,0,16'h0003,16'h0000, 0,0,16'h0000,16'h0000, 1,0,1,0,9'h002,16'h0000, 1,16'h1111,0, 0,16'h0000,0}); // A rd 3
    vecs.push_back(vec_t'{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,1,0,9'h003,16'h0000, 0,16'h1111,0, 1,16'h2222,0});
    vecs.push_back(vec_t'{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,9'h000,16'h0000, 1,16'h3333,0, 0,16'h2222,0});
    vecs.push_back(vec_t'{0,0,16'h0000,16'h0000, 1,0,16'h0200,16'h0000, 0,1,0,0,9'h000,16'h0000, 0,16'h3333,0, 0,16'h2222,0}); // B rd OOR
    vecs.push_back(vec_t'{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,9'h000,16'h0000, 0,16'h3333,0, 0,16'h2222,0});
    vecs.push_back(vec_t'{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,9'h000,16'h0000, 0,16'h3333,0, 1,16'h0000,1});
    vecs.push_back(vec_t'{0,0,16'h0000,16'h0000, 1,1,16'h8000,16'hDEAD, 0,1,0,0,9'h000,16'h0000, 0,16'h3333,0, 0,16'h0000,0}); // B wr OOR
    vecs.push_back(vec_t'{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,9'h000,16'h0000, 0,16'h3333,0, 0,16'h0000,1});
    vecs.push_back(vec_t'{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,9'h000,16'h0000, 0,16'h3333,0, 0,16'h0000,0});

    // Reset
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst a_gnt",    bus.a_gnt,    0);
    check("rst b_gnt",    bus.b_gnt,    0);
    check("rst mem_cs",   bus.mem_cs,   0);
    check("rst mem_we",   bus.mem_we,   0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst a_rvalid", bus.a_rvalid, 0);
    check("rst b_rvalid", bus.b_rvalid, 0);
    check("rst a_rdata",  bus.a_rdata,  0);
    check("rst b_err",    bus.b_err,    0);
    check("rst state",    dbg_state,    0);
    check("rst wait_cnt", dbg_wait,     0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table
    for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);

    // B starvation: A requests every cycle, B forced through at cycle 4
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 16'h0000;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 16'h0004;
      end
      if (c == 5) bus.b_req = 0;
      @(negedge clk);
      check($sformatf("fair c%0d a_gnt", c), bus.a_gnt, (c != 4));
      check($sformatf("fair c%0d b_gnt", c), bus.b_gnt, (c == 4));
      check($sformatf("fair c%0d one_gnt", c), bus.a_gnt & bus.b_gnt, 0);
      if (c == 3) check("fair wait_cnt c3", dbg_wait, 3);
      if (c == 4) check("fair state c4", dbg_state, 1);
      if (c == 5) begin
        check("fair wait_cnt c5", dbg_wait, 0);
        check("fair state c5", dbg_state, 0);
      end
      if (c == 6) begin
        check("fair b_rvalid c6", bus.b_rvalid, 1);
        check("fair b_rdata c6",  bus.b_rdata,  16'h4444);
        check("fair a_rvalid c6", bus.a_rvalid, 0);
      end
      if (c == 7) begin
        check("fair b_rvalid c7", bus.b_rvalid, 0);
        check("fair a_rvalid c7", bus.a_rvalid, 1);
        check("fair a_rdata c7",  bus.a_rdata,  16'h0A0A);
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);

    // Reset while a read is in flight
    @(posedge clk); #1;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 16'h0005;
    @(negedge clk);
    check("mrst a_gnt T", bus.a_gnt, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.a_addr = 16'h0007;
    @(negedge clk);
    check("mrst a_gnt in reset", bus.a_gnt, 0);
    check("mrst mem_cs T+1", bus.mem_cs, 1);
    check("mrst mem_addr T+1", bus.mem_addr, 9'h005);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.a_req = 0;
    @(negedge clk);
    check("mrst mem_cs",   bus.mem_cs,   0);
    check("mrst a_rvalid", bus.a_rvalid, 0);
    check("mrst a_rdata",  bus.a_rdata,  0);
    check("mrst b_rdata",  bus.b_rdata,  0);
    check("mrst a_err",    bus.a_err,    0);
    check("mrst state",    dbg_state,    0);
    check("mrst wait_cnt", dbg_wait,     0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mrst a_rvalid late", bus.a_rvalid, 0);
    check("mrst mem_cs late",   bus.mem_cs,   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 16-bit x 512-word data memory.
- Requester A is the CPU load/store unit and has fixed priority.
- Requester B is the debug/program loader (DMA-style) and gets a guaranteed slot after a bounded wait.
- Registers one memory command per cycle, tracks outstanding reads and routes read data back to the owner.

Parameters:
- AW, 16, requester address width
- DW, 16, data width
- DEPTH, 512, number of implemented memory words; the memory address is addr[8:0]
- RD_LAT, 1, memory read latency in cycles, counted from the cycle the command is on the mem_* pins to the cycle mem_rdata is valid (1..3)
- MAX_WAIT, 4, cycles B may be denied before it is forced a grant (1..15)

Ports:
- Clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- a_req  in  1  A access request; held until a_gnt
- a_we  in  1  A write (1) / read (0)
- a_addr  in  AW  A word address
- a_wdata  in  DW  A write data
- a_gnt  out  1  A request accepted this cycle (combinational)
- a_rvalid  out  1  A read data valid, one-cycle pulse
- a_rdata  out  DW  A read data
- a_err  out  1  A out-of-range access, one-cycle pulse aligned with the response
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err  same as the A ports, for requester B
- mem_cs  out  1  memory access enable (active high)
- mem_we  out  1  memory write enable
- mem_addr  out  9  memory word address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data

Behaviour:
- Reset (reset=0 at a rising edge):
  - All outputs are 0.
  - FSM goes to PRIO_A and wait_cnt goes to 0.
  - The read-tag pipeline is flushed; reads in flight produce no rvalid.
- FSM states:
  - PRIO_A: if a_req, A wins; else if b_req, B wins.
  - FORCE_B: if b_req, B wins; A is denied.
- FSM transitions:
  - PRIO_A -> FORCE_B when b_req && !b_gnt and wait_cnt == MAX_WAIT-1; wait_cnt increments on every denied b_req cycle.
  - FORCE_B -> PRIO_A after B is granted. Also FORCE_B -> PRIO_A if b_req drops, with wait_cnt cleared.
  - Any b_gnt clears wait_cnt.
- Grants:
  - At most one of a_gnt/b_gnt is high per cycle.
  - A grant is only asserted while the matching req is high.
  - A request is consumed by the grant, so the requester may change its inputs in the next cycle.
- Command timing:
  - Grant at cycle T puts the registered command on mem_cs/mem_we/mem_addr/mem_wdata at T+1.
  - When no grant occurs, mem_cs=0 and mem_we=0 in the following cycle.
- Reads:
  - A read granted at T gives rvalid and rdata to the owner at T+1+RD_LAT.
  - The owner tag travels through an RD_LAT+1 deep shift register.
  - rdata holds its last value when rvalid=0.
- Writes: no response pulse. A write is complete once it is on the mem pins.
- Back-to-back accesses:
  - One new grant per cycle with no bubbles.
  - Read responses return in grant order.
  - Read-after-write to the same address granted on consecutive cycles returns the new data; this is guaranteed by the command order.
- Out-of-range accesses (addr >= DEPTH):
  - The access is granted, but mem_cs stays 0 for that slot.
  - A write is dropped. A read returns rdata=0 with rvalid.
  - err pulses in the response cycle; for writes that is T+1.
- Simultaneous a_req and b_req: resolved by the current FSM state as above; the denied requester holds its request.
- Reset mid-operation: the command issued in the reset cycle is suppressed (mem_cs=0), and no later rvalid appears for it.

Test Plan:
- Single A read of addr 0x0005 with memory holding 0x1234: a_gnt at T, mem_cs=1/mem_we=0/mem_addr=5 at T+1, a_rvalid=1 and a_rdata=0x1234 at T+2 (RD_LAT=1).
- A writes 0xBEEF to addr 0x01FF, then reads it on the next cycle: mem_we=1 then 0 on consecutive cycles, a_rdata=0xBEEF.
- a_req held high continuously and b_req high from cycle 0 (MAX_WAIT=4): b_gnt at cycle 4, a_gnt on cycles 0-3 and 5+, never both in one cycle; wait_cnt returns to 0.
- Interleaved reads (A addr 1, B addr 2, A addr 3): rvalid pulses route to the correct owner in order with matching data and no cross-talk.
- B reads addr 0x0200: no mem_cs, b_rvalid=1 with b_rdata=0 and b_err=1. B writes addr 0x8000: dropped, b_err=1 at T+1.
- A read granted, then reset=0 asserted for one cycle before data return: no a_rvalid, all outputs 0, FSM in PRIO_A.
